// File: rtl/dcache_write_pkg.sv
// Shared types and defaults for the data-array write queue.
//   wr_req_t  : full write request (way_en, addr, wmask, data, src) at default widths
//   wr_ctrl_t : width-independent control fields carried alongside the data
package dcache_write_pkg;

  localparam int unsigned DefDepth    = 4;
  localparam int unsigned DefAddrW    = 12;
  localparam int unsigned DefDataW    = 64;
  localparam int unsigned DefMaxStall = 15;

  typedef struct packed {
    logic                way_en;
    logic [DefAddrW-1:0] addr;
    logic                wmask;
    logic [DefDataW-1:0] data;
    logic                src;
  } wr_req_t;

  // Control fields stored with each entry; address and data are kept separately
  // so their widths can follow the top-level parameters.
  typedef struct packed {
    logic way_en;
    logic wmask;
    logic src;
  } wr_ctrl_t;

endpackage

// File: rtl/write_fifo_core.sv
// Pointer FIFO with per-entry valid bits.
//   clk_i/rst_ni           : clock, async active-low reset (pointers, count, valids)
//   push_i/push_addr_i/... : enqueue request; ignored when full
//   pop_i                  : dequeue head; ignored when empty
//   head_addr_o/payload_o  : head entry (don't-care when empty)
//   count_o/full_o/empty_o : occupancy
//   entry_valid_o/addr_o   : whole entry array, for address-hazard compares
module write_fifo_core #(
  parameter int unsigned Depth    = 4,
  parameter int unsigned AddrW    = 12,
  parameter int unsigned PayloadW = 67,
  localparam int unsigned PtrW    = $clog2(Depth),
  localparam int unsigned CntW    = PtrW + 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  logic [AddrW-1:0]             push_addr_i,
  input  logic [PayloadW-1:0]          push_payload_i,
  input  logic                         pop_i,
  output logic [AddrW-1:0]             head_addr_o,
  output logic [PayloadW-1:0]          head_payload_o,
  output logic [CntW-1:0]              count_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [Depth-1:0]             entry_valid_o,
  output logic [Depth-1:0][AddrW-1:0]  entry_addr_o
);

  localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

  logic [PtrW-1:0]                wptr_q, wptr_d;
  logic [PtrW-1:0]                rptr_q, rptr_d;
  logic [CntW-1:0]                count_q, count_d;
  logic [Depth-1:0]               valid_q, valid_d;
  logic [Depth-1:0][AddrW-1:0]    addr_mem_q;
  logic [Depth-1:0][PayloadW-1:0] payload_mem_q;
  logic                           push_eff, pop_eff;

  assign full_o   = (count_q == FullCnt);
  assign empty_o  = (count_q == '0);
  assign push_eff = push_i & ~full_o;
  assign pop_eff  = pop_i & ~empty_o;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    valid_d = valid_q;
    // Pop is applied first; push and pop never target the same slot because a
    // push needs a free slot and a pop needs an occupied one.
    if (pop_eff) begin
      valid_d[rptr_q] = 1'b0;
      rptr_d          = rptr_q + 1'b1;
    end
    if (push_eff) begin
      valid_d[wptr_q] = 1'b1;
      wptr_d          = wptr_q + 1'b1;
    end
    case ({push_eff, pop_eff})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Entry storage is deliberately not reset; valid bits qualify it.
  always_ff @(posedge clk_i) begin
    if (push_eff) begin
      addr_mem_q[wptr_q]    <= push_addr_i;
      payload_mem_q[wptr_q] <= push_payload_i;
    end
  end

  assign head_addr_o    = addr_mem_q[rptr_q];
  assign head_payload_o = payload_mem_q[rptr_q];
  assign count_o        = count_q;
  assign entry_valid_o  = valid_q;
  assign entry_addr_o   = addr_mem_q;

endmodule

// File: rtl/data_write_queue.sv
// Data-array write queue: buffers arbitrated write requests and drains them to
// the SRAM write port whenever the read path is not using the array.
//   clock/reset        : sole clock, async active-low reset
//   io_enq_*           : request from the write arbiter (valid/ready handshake)
//   io_sram_block      : read path owns the array this cycle
//   io_sram_*          : SRAM write port driven from the FIFO head
//   io_sram_forced     : write issued despite io_sram_block (starvation guard)
//   io_ack_0/1         : one-cycle completion pulse per source, cycle after commit
//   io_rd_addr/rd_hit  : read-after-write hazard probe against pending entries
//   io_count           : registered occupancy
module data_write_queue
  import dcache_write_pkg::*;
#(
  parameter int unsigned DEPTH     = DefDepth,
  parameter int unsigned ADDR_W    = DefAddrW,
  parameter int unsigned DATA_W    = DefDataW,
  parameter int unsigned MAX_STALL = DefMaxStall,
  localparam int unsigned CntW     = $clog2(DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset,
  output logic              io_enq_ready,
  input  logic              io_enq_valid,
  input  logic              io_enq_bits_way_en,
  input  logic [ADDR_W-1:0] io_enq_bits_addr,
  input  logic              io_enq_bits_wmask,
  input  logic [DATA_W-1:0] io_enq_bits_data,
  input  logic              io_enq_src,
  input  logic              io_sram_block,
  output logic              io_sram_wen,
  output logic              io_sram_way_en,
  output logic [ADDR_W-1:0] io_sram_addr,
  output logic              io_sram_wmask,
  output logic [DATA_W-1:0] io_sram_data,
  output logic              io_sram_forced,
  output logic              io_ack_0,
  output logic              io_ack_1,
  input  logic [ADDR_W-1:0] io_rd_addr,
  output logic              io_rd_hit,
  output logic [CntW-1:0]   io_count
);

  localparam int unsigned     PayloadW = $bits(wr_ctrl_t) + DATA_W;
  localparam int unsigned     StallW   = $clog2(MAX_STALL + 1);
  localparam logic [StallW-1:0] StallMax = StallW'(MAX_STALL);

  wr_ctrl_t                     push_ctrl, head_ctrl;
  logic [PayloadW-1:0]          head_payload;
  logic                         fifo_full, fifo_empty, push;
  logic [DEPTH-1:0]             entry_valid;
  logic [DEPTH-1:0][ADDR_W-1:0] entry_addr;
  logic [StallW-1:0]            stall_q, stall_d;
  logic                         ack0_q, ack0_d, ack1_q, ack1_d;

  assign push_ctrl = '{way_en: io_enq_bits_way_en, wmask: io_enq_bits_wmask, src: io_enq_src};

  // Ready depends only on registered occupancy, so a full queue never accepts
  // even when the head is being written in the same cycle.
  assign io_enq_ready = ~fifo_full;
  assign push         = io_enq_valid & io_enq_ready;

  write_fifo_core #(
    .Depth   (DEPTH),
    .AddrW   (ADDR_W),
    .PayloadW(PayloadW)
  ) u_fifo (
    .clk_i         (clock),
    .rst_ni        (reset),
    .push_i        (push),
    .push_addr_i   (io_enq_bits_addr),
    .push_payload_i({push_ctrl, io_enq_bits_data}),
    .pop_i         (io_sram_wen),
    .head_addr_o   (io_sram_addr),
    .head_payload_o(head_payload),
    .count_o       (io_count),
    .full_o        (fifo_full),
    .empty_o       (fifo_empty),
    .entry_valid_o (entry_valid),
    .entry_addr_o  (entry_addr)
  );

  assign {head_ctrl, io_sram_data} = head_payload;
  assign io_sram_way_en = head_ctrl.way_en;
  assign io_sram_wmask  = head_ctrl.wmask;

  // A saturated stall counter overrides the read path's claim on the array.
  assign io_sram_wen    = ~fifo_empty & (~io_sram_block | (stall_q == StallMax));
  assign io_sram_forced = io_sram_wen & io_sram_block;

  always_comb begin
    stall_d = stall_q;
    if (fifo_empty || io_sram_wen) begin
      stall_d = '0;
    end else if (io_sram_block && (stall_q != StallMax)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  assign ack0_d = io_sram_wen & ~head_ctrl.src;
  assign ack1_d = io_sram_wen & head_ctrl.src;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
    end else begin
      stall_q <= stall_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
    end
  end

  assign io_ack_0 = ack0_q;
  assign io_ack_1 = ack1_q;

  // The head is still valid during its write cycle, so it keeps reporting a hit.
  always_comb begin
    io_rd_hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      io_rd_hit = io_rd_hit | (entry_valid[i] & (entry_addr[i] == io_rd_addr));
    end
  end

endmodule

// File: tb/tb_data_write_queue.sv
module tb_data_write_queue;
  import dcache_write_pkg::*;

  localparam int unsigned Depth    = 4;
  localparam int unsigned MaxStall = 15;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        io_enq_ready, io_enq_valid, io_enq_bits_way_en, io_enq_bits_wmask, io_enq_src;
  logic [11:0] io_enq_bits_addr, io_sram_addr, io_rd_addr;
  logic [63:0] io_enq_bits_data, io_sram_data;
  logic        io_sram_block, io_sram_wen, io_sram_way_en, io_sram_wmask, io_sram_forced;
  logic        io_ack_0, io_ack_1, io_rd_hit;
  logic [2:0]  io_count;

  data_write_queue dut (
    .clock             (clock),
    .reset             (reset),
    .io_enq_ready      (io_enq_ready),
    .io_enq_valid      (io_enq_valid),
    .io_enq_bits_way_en(io_enq_bits_way_en),
    .io_enq_bits_addr  (io_enq_bits_addr),
    .io_enq_bits_wmask (io_enq_bits_wmask),
    .io_enq_bits_data  (io_enq_bits_data),
    .io_enq_src        (io_enq_src),
    .io_sram_block     (io_sram_block),
    .io_sram_wen       (io_sram_wen),
    .io_sram_way_en    (io_sram_way_en),
    .io_sram_addr      (io_sram_addr),
    .io_sram_wmask     (io_sram_wmask),
    .io_sram_data      (io_sram_data),
    .io_sram_forced    (io_sram_forced),
    .io_ack_0          (io_ack_0),
    .io_ack_1          (io_ack_1),
    .io_rd_addr        (io_rd_addr),
    .io_rd_hit         (io_rd_hit),
    .io_count          (io_count)
  );

  always #5 clock = ~clock;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference model: ordered list of pending requests plus blocked-cycle tally.
  wr_req_t     mq[$];
  int unsigned blocked = 0;
  logic        exp_ack0 = 1'b0, exp_ack1 = 1'b0;
  bit          will_push, will_pop;

  typedef struct {
    logic        v;
    logic [11:0] a;
    logic [63:0] d;
    logic        s;
    logic        b;
    logic [11:0] rd;
    int          cnt;
    logic        rdy;
    logic        wen;
    logic [11:0] wa;
    logic        hit;
    logic        ack0;
    logic        ack1;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] dat(input logic [11:0] a);
    return 64'hA5A5_0000_0000_0000 | {52'h0, a};
  endfunction

  task automatic drive(input logic v, input logic [11:0] a, input logic [63:0] d,
                       input logic s, input logic b, input logic [11:0] rd);
    @(negedge clock);
    io_enq_valid       = v;
    io_enq_bits_addr   = a;
    io_enq_bits_data   = d;
    io_enq_bits_way_en = a[0];
    io_enq_bits_wmask  = a[1];
    io_enq_src         = s;
    io_sram_block      = b;
    io_rd_addr         = rd;
    #1;
  endtask

  task automatic check_model();
    bit e_ready, e_wen, e_hit;
    e_ready = (mq.size() != Depth);
    e_wen   = (mq.size() != 0) && (!io_sram_block || blocked == MaxStall);
    e_hit   = 1'b0;
    foreach (mq[i]) if (mq[i].addr == io_rd_addr) e_hit = 1'b1;
    chk("m_count", 64'(io_count), 64'(mq.size()));
    chk("m_ready", 64'(io_enq_ready), 64'(e_ready));
    chk("m_wen", 64'(io_sram_wen), 64'(e_wen));
    chk("m_forced", 64'(io_sram_forced), 64'(e_wen && io_sram_block));
    chk("m_hit", 64'(io_rd_hit), 64'(e_hit));
    chk("m_ack0", 64'(io_ack_0), 64'(exp_ack0));
    chk("m_ack1", 64'(io_ack_1), 64'(exp_ack1));
    if (mq.size() != 0) begin
      chk("m_head_addr", 64'(io_sram_addr), 64'(mq[0].addr));
      chk("m_head_data", io_sram_data, mq[0].data);
      chk("m_head_way", 64'(io_sram_way_en), 64'(mq[0].way_en));
      chk("m_head_wmask", 64'(io_sram_wmask), 64'(mq[0].wmask));
    end
    will_push = io_enq_valid && e_ready;
    will_pop  = e_wen;
  endtask

  task automatic advance();
    bit      was_empty;
    wr_req_t n;
    @(posedge clock);
    was_empty = (mq.size() == 0);
    exp_ack0  = 1'b0;
    exp_ack1  = 1'b0;
    if (will_pop) begin
      exp_ack0 = ~mq[0].src;
      exp_ack1 = mq[0].src;
      void'(mq.pop_front());
      blocked = 0;
    end else if (was_empty) begin
      blocked = 0;
    end else if (io_sram_block && blocked < MaxStall) begin
      blocked++;
    end
    if (will_push) begin
      n.way_en = io_enq_bits_way_en;
      n.addr   = io_enq_bits_addr;
      n.wmask  = io_enq_bits_wmask;
      n.data   = io_enq_bits_data;
      n.src    = io_enq_src;
      mq.push_back(n);
    end
  endtask

  task automatic step(input logic v, input logic [11:0] a, input logic s, input logic b,
                      input logic [11:0] rd);
    drive(v, a, dat(a), s, b, rd);
    check_model();
    advance();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    io_enq_valid = 0; io_enq_bits_addr = 0; io_enq_bits_data = 0; io_enq_bits_way_en = 0;
    io_enq_bits_wmask = 0; io_enq_src = 0; io_sram_block = 0; io_rd_addr = 12'h123;

    // v a d s b rd | cnt rdy wen wa hit ack0 ack1
    tbl[0]  = '{1, 12'h123, 64'hDEADBEEF, 1, 0, 12'h123, 0, 1, 0, 12'h000, 0, 0, 0};
    tbl[1]  = '{0, 12'h000, 64'h0,        0, 0, 12'h123, 1, 1, 1, 12'h123, 1, 0, 0};
    tbl[2]  = '{0, 12'h000, 64'h0,        0, 0, 12'h123, 0, 1, 0, 12'h000, 0, 0, 1};
    tbl[3]  = '{0, 12'h000, 64'h0,        0, 0, 12'h123, 0, 1, 0, 12'h000, 0, 0, 0};
    tbl[4]  = '{1, 12'h040, dat(12'h040), 0, 1, 12'h7FF, 0, 1, 0, 12'h000, 0, 0, 0};
    tbl[5]  = '{1, 12'h7FF, dat(12'h7FF), 1, 1, 12'h7FF, 1, 1, 0, 12'h000, 0, 0, 0};
    tbl[6]  = '{1, 12'h200, dat(12'h200), 0, 1, 12'h7FF, 2, 1, 0, 12'h000, 1, 0, 0};
    tbl[7]  = '{1, 12'h300, dat(12'h300), 1, 1, 12'h7FF, 3, 1, 0, 12'h000, 1, 0, 0};
    tbl[8]  = '{1, 12'h400, dat(12'h400), 0, 1, 12'h7FF, 4, 0, 0, 12'h000, 1, 0, 0};
    tbl[9]  = '{1, 12'h400, dat(12'h400), 0, 0, 12'h041, 4, 0, 1, 12'h040, 0, 0, 0};
    tbl[10] = '{1, 12'h400, dat(12'h400), 0, 0, 12'h7FF, 3, 1, 1, 12'h7FF, 1, 1, 0};
    tbl[11] = '{0, 12'h000, 64'h0,        0, 0, 12'h7FF, 3, 1, 1, 12'h200, 0, 0, 1};
    tbl[12] = '{0, 12'h000, 64'h0,        0, 0, 12'h7FF, 2, 1, 1, 12'h300, 0, 1, 0};
    tbl[13] = '{0, 12'h000, 64'h0,        0, 0, 12'h7FF, 1, 1, 1, 12'h400, 0, 0, 1};
    tbl[14] = '{0, 12'h000, 64'h0,        0, 0, 12'h7FF, 0, 1, 0, 12'h000, 0, 1, 0};
    tbl[15] = '{0, 12'h000, 64'h0,        0, 0, 12'h7FF, 0, 1, 0, 12'h000, 0, 0, 0};

    // Reset state
    #12;
    chk("rst_count", 64'(io_count), 64'd0);
    chk("rst_wen", 64'(io_sram_wen), 64'd0);
    chk("rst_ready", 64'(io_enq_ready), 64'd1);
    chk("rst_acks", 64'({io_ack_0, io_ack_1}), 64'd0);
    chk("rst_hit", 64'(io_rd_hit), 64'd0);
    @(negedge clock);
    reset = 1'b1;

    // Directed table: single write, fill/hold-off, FIFO-order drain, hazard probe
    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].s, tbl[i].b, tbl[i].rd);
      check_model();
      chk($sformatf("v%0d_count", i), 64'(io_count), 64'(tbl[i].cnt));
      chk($sformatf("v%0d_ready", i), 64'(io_enq_ready), 64'(tbl[i].rdy));
      chk($sformatf("v%0d_wen", i), 64'(io_sram_wen), 64'(tbl[i].wen));
      if (tbl[i].wen) chk($sformatf("v%0d_waddr", i), 64'(io_sram_addr), 64'(tbl[i].wa));
      if (i == 1) chk("v1_data", io_sram_data, 64'hDEADBEEF);
      chk($sformatf("v%0d_hit", i), 64'(io_rd_hit), 64'(tbl[i].hit));
      chk($sformatf("v%0d_ack0", i), 64'(io_ack_0), 64'(tbl[i].ack0));
      chk($sformatf("v%0d_ack1", i), 64'(io_ack_1), 64'(tbl[i].ack1));
      advance();
    end

    // Wrap: move pointers to DEPTH-1, then push/pop concurrently at count 2
    step(1, 12'h0A1, 0, 0, 12'h0);
    step(0, 12'h000, 0, 0, 12'h0);
    step(1, 12'h0B1, 1, 1, 12'h0);
    step(1, 12'h0B2, 0, 1, 12'h0);
    step(1, 12'h0B3, 1, 0, 12'h0);
    drive(0, 12'h000, 64'h0, 0, 0, 12'h0B3);
    chk("wrap_count", 64'(io_count), 64'd2);
    chk("wrap_head", 64'(io_sram_addr), 64'h0B2);
    chk("wrap_hit", 64'(io_rd_hit), 64'd1);
    check_model();
    advance();
    for (int i = 0; i < 3; i++) step(0, 12'h000, 0, 0, 12'h0B3);

    // Starvation: 15 blocked cycles, then a forced write on the 16th
    step(1, 12'h0C1, 0, 1, 12'h0);
    for (int i = 0; i < 15; i++) begin
      drive(0, 12'h000, 64'h0, 0, 1, 12'h0);
      chk($sformatf("starve%0d_wen", i), 64'(io_sram_wen), 64'd0);
      check_model();
      advance();
    end
    drive(0, 12'h000, 64'h0, 0, 1, 12'h0);
    chk("starve_wen", 64'(io_sram_wen), 64'd1);
    chk("starve_forced", 64'(io_sram_forced), 64'd1);
    check_model();
    advance();
    // Counter must have cleared: a new entry is not forced right away
    step(1, 12'h0C2, 1, 1, 12'h0);
    drive(0, 12'h000, 64'h0, 0, 1, 12'h0);
    chk("starve_clear", 64'(io_sram_wen), 64'd0);
    check_model();
    advance();
    for (int i = 0; i < 16; i++) step(0, 12'h000, 0, 1, 12'h0);
    step(0, 12'h000, 0, 0, 12'h0);

    // Reset mid-drain with an ack pending
    step(1, 12'h0D1, 0, 1, 12'h0);
    step(1, 12'h0D2, 1, 1, 12'h0);
    step(1, 12'h0D3, 0, 1, 12'h0);
    step(0, 12'h000, 0, 0, 12'h0D2);
    drive(0, 12'h000, 64'h0, 0, 0, 12'h0D2);
    chk("pre_rst_ack0", 64'(io_ack_0), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_count", 64'(io_count), 64'd0);
    chk("mid_rst_wen", 64'(io_sram_wen), 64'd0);
    chk("mid_rst_acks", 64'({io_ack_0, io_ack_1}), 64'd0);
    chk("mid_rst_hit", 64'(io_rd_hit), 64'd0);
    mq.delete();
    blocked  = 0;
    exp_ack0 = 1'b0;
    exp_ack1 = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) step(0, 12'h000, 0, 0, 12'h0D3);

    // Randomized traffic against the model; phases vary block pressure
    for (int i = 0; i < 800; i++) begin
      int unsigned bp;
      logic [11:0] a;
      bp = (i < 200) ? 30 : (i < 400) ? 70 : (i < 600) ? 97 : 50;
      a  = 12'({$urandom_range(0, 15)} << 4);
      step(1'($urandom_range(0, 99) < 60), a, 1'($urandom), 1'($urandom_range(0, 99) < bp),
           12'({$urandom_range(0, 15)} << 4));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
